// File: rtl/video_timing_pkg.sv
// Default 640x480@60 timing constants and the beam-position type shared by the
// timing generator and everything downstream of it on the video path.
package video_timing_pkg;

  localparam int unsigned POS_W = 10;
  typedef logic [POS_W-1:0] pos_t;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Inclusive window test used by the sync decoders.
  function automatic logic in_window(input pos_t p, input pos_t lo, input pos_t hi);
    return (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/vga_hvsync_generator_if.sv
// Timing bundle from the sync generator to pixel pipelines and framebuffer readers.
interface vga_hvsync_generator_if;
  import video_timing_pkg::*;

  logic hsync;
  logic vsync;
  logic display_on;
  pos_t hpos;
  pos_t vpos;

  modport master (
    output hsync,
    output vsync,
    output display_on,
    output hpos,
    output vpos
  );

  modport slave (
    input hsync,
    input vsync,
    input display_on,
    input hpos,
    input vpos
  );

endinterface

// File: rtl/vga_hvsync_generator.sv
// Free-running VGA beam counter with combinational sync/blanking decodes; all five
// outputs come from the same pair of registers so they stay cycle-aligned.
module vga_hvsync_generator
  import video_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_hvsync_generator_if.master vga
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam pos_t H_LAST     = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST     = pos_t'(V_TOTAL - 1);
  localparam pos_t H_VIS      = pos_t'(H_DISPLAY);
  localparam pos_t V_VIS      = pos_t'(V_DISPLAY);
  localparam pos_t HS_START   = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t HS_END     = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam pos_t VS_START   = pos_t'(V_DISPLAY + V_FRONT);
  localparam pos_t VS_END     = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  pos_t hpos_reg;
  pos_t hpos_next;
  pos_t vpos_reg;
  pos_t vpos_next;
  logic h_wrap;

  // ">=" rather than "==" so a corrupted counter recovers on the very next edge.
  assign h_wrap = (hpos_reg >= H_LAST);

  always_comb begin
    hpos_next = hpos_reg + pos_t'(1);
    vpos_next = vpos_reg;
    if (h_wrap) begin
      hpos_next = '0;
    end
    if (vpos_reg > V_LAST) begin
      vpos_next = '0;
    end else if (h_wrap) begin
      vpos_next = (vpos_reg == V_LAST) ? '0 : vpos_reg + pos_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hpos_reg <= '0;
      vpos_reg <= '0;
    end else begin
      hpos_reg <= hpos_next;
      vpos_reg <= vpos_next;
    end
  end

  assign vga.hpos       = hpos_reg;
  assign vga.vpos       = vpos_reg;
  assign vga.hsync      = ~in_window(hpos_reg, HS_START, HS_END);
  assign vga.vsync      = ~in_window(vpos_reg, VS_START, VS_END);
  assign vga.display_on = (hpos_reg < H_VIS) && (vpos_reg < V_VIS);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Bench: a full-size generator for reset/horizontal timing plus a scaled-down one
// so vertical sync, frame wrap and mid-frame reset fit in a short run.
module tb_vga_hvsync_generator;
  import video_timing_pkg::*;

  typedef struct {
    int   cyc;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic de;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a = 1'b0;
  logic reset_b = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic rq [2];

  exp_t sb_a[$];
  exp_t sb_b[$];

  int   hs_run [2];
  int   vs_run [2];
  int   hs_fall [2];
  int   vs_fall [2];
  int   hs_pulses [2];
  int   vs_pulses [2];
  logic hs_prev [2];
  logic vs_prev [2];

  localparam int REL = 5;

  always #5 clk = ~clk;

  vga_hvsync_generator_if vga_a ();
  vga_hvsync_generator_if vga_b ();

  vga_hvsync_generator dut_a (
    .clk   (clk),
    .reset (reset_a),
    .vga   (vga_a)
  );

  vga_hvsync_generator #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .vga   (vga_b)
  );

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rq[0] <= reset_a;
    rq[1] <= reset_b;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 60)
        $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int id, input int c, input int h, input int v,
                      input logic hs, input logic vs, input logic de);
    exp_t e;
    e.cyc = c; e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.de = de;
    if (id == 0) sb_a.push_back(e);
    else         sb_b.push_back(e);
  endtask

  task automatic compare(input string name, input exp_t e, input logic [9:0] h,
                         input logic [9:0] v, input logic hs, input logic vs, input logic de);
    $display("vec %s cyc=%0d hpos=%0d vpos=%0d hsync=%0b vsync=%0b de=%0b",
             name, cyc, h, v, hs, vs, de);
    chk({name, ".cyc"}, cyc, e.cyc);
    chk({name, ".hpos"}, {22'd0, h}, e.h);
    chk({name, ".vpos"}, {22'd0, v}, e.v);
    chk({name, ".hsync"}, {31'd0, hs}, {31'd0, e.hs});
    chk({name, ".vsync"}, {31'd0, vs}, {31'd0, e.vs});
    chk({name, ".display_on"}, {31'd0, de}, {31'd0, e.de});
  endtask

  task automatic trk_init(input int id);
    hs_prev[id] = 1'b1; vs_prev[id] = 1'b1;
    hs_run[id]  = 0;    vs_run[id]  = 0;
    hs_fall[id] = -1;   vs_fall[id] = -1;
  endtask

  // Range, pulse-width and period checks on every running cycle.
  task automatic track(input int id, input logic hs, input logic vs, input logic [9:0] h,
                       input logic [9:0] v, input int ht, input int vt, input int hsw, input int vsw);
    chk(id == 0 ? "A.hpos_range" : "B.hpos_range", {31'd0, (int'(h) < ht)}, 1);
    chk(id == 0 ? "A.vpos_range" : "B.vpos_range", {31'd0, (int'(v) < vt)}, 1);
    if (hs_prev[id] && !hs) begin
      if (hs_fall[id] >= 0) chk(id == 0 ? "A.hsync_period" : "B.hsync_period", cyc - hs_fall[id], ht);
      hs_fall[id] = cyc;
      hs_run[id]  = 0;
    end
    if (!hs) hs_run[id]++;
    if (!hs_prev[id] && hs && hs_fall[id] >= 0) begin
      chk(id == 0 ? "A.hsync_width" : "B.hsync_width", hs_run[id], hsw);
      hs_pulses[id]++;
    end
    if (vs_prev[id] && !vs) begin
      chk(id == 0 ? "A.vsync_fall_hpos" : "B.vsync_fall_hpos", {22'd0, h}, 0);
      if (vs_fall[id] >= 0) chk(id == 0 ? "A.frame_period" : "B.frame_period", cyc - vs_fall[id], ht * vt);
      vs_fall[id] = cyc;
      vs_run[id]  = 0;
    end
    if (!vs) vs_run[id]++;
    if (!vs_prev[id] && vs && vs_fall[id] >= 0) begin
      chk(id == 0 ? "A.vsync_rise_hpos" : "B.vsync_rise_hpos", {22'd0, h}, 0);
      chk(id == 0 ? "A.vsync_width" : "B.vsync_width", vs_run[id], vsw * ht);
      vs_pulses[id]++;
    end
    hs_prev[id] = hs;
    vs_prev[id] = vs;
  endtask

  // Scoreboard monitor: pops an expectation whenever its cycle comes up.
  always @(negedge clk) begin
    exp_t e;
    while (sb_a.size() > 0 && sb_a[0].cyc <= cyc) begin
      e = sb_a.pop_front();
      compare("A", e, vga_a.hpos, vga_a.vpos, vga_a.hsync, vga_a.vsync, vga_a.display_on);
    end
    while (sb_b.size() > 0 && sb_b[0].cyc <= cyc) begin
      e = sb_b.pop_front();
      compare("B", e, vga_b.hpos, vga_b.vpos, vga_b.hsync, vga_b.vsync, vga_b.display_on);
    end
    if (rq[0] === 1'b1) track(0, vga_a.hsync, vga_a.vsync, vga_a.hpos, vga_a.vpos, 800, 525, 96, 2);
    else                trk_init(0);
    if (rq[1] === 1'b1) track(1, vga_b.hsync, vga_b.vsync, vga_b.hpos, vga_b.vpos, 15, 13, 3, 2);
    else                trk_init(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      trk_init(i);
      hs_pulses[i] = 0;
      vs_pulses[i] = 0;
    end

    // Full-size timing: offsets from the last reset edge.
    push(0, REL + 0,    0,   0, 1, 1, 1);
    push(0, REL + 1,    1,   0, 1, 1, 1);
    push(0, REL + 639,  639, 0, 1, 1, 1);
    push(0, REL + 640,  640, 0, 1, 1, 0);
    push(0, REL + 655,  655, 0, 1, 1, 0);
    push(0, REL + 656,  656, 0, 0, 1, 0);
    push(0, REL + 751,  751, 0, 0, 1, 0);
    push(0, REL + 752,  752, 0, 1, 1, 0);
    push(0, REL + 799,  799, 0, 1, 1, 0);
    push(0, REL + 800,  0,   1, 1, 1, 1);
    push(0, REL + 3100, 700, 3, 0, 1, 0);

    // Scaled timing: H 8/2/3/2 (total 15), V 6/2/2/3 (total 13).
    push(1, REL + 0,   0,  0,  1, 1, 1);
    push(1, REL + 7,   7,  0,  1, 1, 1);
    push(1, REL + 8,   8,  0,  1, 1, 0);
    push(1, REL + 9,   9,  0,  1, 1, 0);
    push(1, REL + 10,  10, 0,  0, 1, 0);
    push(1, REL + 12,  12, 0,  0, 1, 0);
    push(1, REL + 13,  13, 0,  1, 1, 0);
    push(1, REL + 14,  14, 0,  1, 1, 0);
    push(1, REL + 15,  0,  1,  1, 1, 1);
    push(1, REL + 78,  3,  5,  1, 1, 1);
    push(1, REL + 93,  3,  6,  1, 1, 0);
    push(1, REL + 119, 14, 7,  1, 1, 0);
    push(1, REL + 120, 0,  8,  1, 0, 0);
    push(1, REL + 149, 14, 9,  1, 0, 0);
    push(1, REL + 150, 0,  10, 1, 1, 0);
    push(1, REL + 194, 14, 12, 1, 1, 0);
    push(1, REL + 195, 0,  0,  1, 1, 1);
    push(1, REL + 650, 5,  4,  1, 1, 1);
    push(1, 656, 0, 0, 1, 1, 1);
    push(1, 658, 0, 0, 1, 1, 1);
    push(1, 660, 0, 0, 1, 1, 1);
    push(1, 661, 1, 0, 1, 1, 1);
    push(1, 675, 0, 1, 1, 1, 1);

    while (cyc < REL) @(negedge clk);
    reset_a = 1'b1;
    reset_b = 1'b1;

    while (cyc < 655) @(negedge clk);
    chk("B.vsync_pulses_3_frames", vs_pulses[1], 3);
    chk("B.hsync_pulses", hs_pulses[1], 43);
    reset_b = 1'b0;

    while (cyc < 660) @(negedge clk);
    reset_b = 1'b1;

    while (cyc < 3300) @(negedge clk);
    chk("A.hsync_pulses", hs_pulses[0], 4);
    chk("A.vsync_pulses", vs_pulses[0], 0);
    chk("A.vectors_left", sb_a.size(), 0);
    chk("B.vectors_left", sb_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
